pkt_word_counter: RTL
=====================

// Module: pkt_word_counter
// PURPOSE
//  In-line Avalon-ST packet monitor: forwards msg_in to msg_out unchanged and counts accepted beats.
//  Tracks the running word count of the current packet, latches the length of each completed packet,
//  counts completed packets, and flags framing and length errors.
//  Sits between the message source and the AES datapath; ready is honoured, so it is a true pass-through.
// PARAMETERS
//  WORD_CNT_W     WORD_COUNTER_SIZE  width of cntr/last_len
//  PKT_CNT_W      32                 width of pkt_cnt
//  SATURATE       1                  1: word counter sticks at all-ones; 0: wraps to 0
//  MAX_PKT_WORDS  2**WORD_CNT_W-1    longest legal packet in beats (1..2**WORD_CNT_W-1)
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           asynchronous active-low reset
//  msg_in        -    if          avalon_st_if.slave, upstream stream
//  msg_out       -    if          avalon_st_if.master, downstream stream
//  clr_stats     in   1           sync clear of pkt_cnt and err_sticky
//  cntr          out  WORD_CNT_W  beats accepted so far in current/last packet
//  last_len      out  WORD_CNT_W  length of most recently closed packet
//  last_len_vld  out  1           1-cycle pulse: last_len updated
//  pkt_cnt       out  PKT_CNT_W   number of packets closed by a legal eop (wraps)
//  err_sticky    out  3           [0] no_sop, [1] no_eop, [2] too_long; sticky until clr_stats
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Reset mid-packet discards the packet; no length is latched.
//  - Pass-through is combinational: msg_out.{valid,sop,eop,data}=msg_in.*; msg_in.ready=msg_out.ready.
//  - beat = msg_in.valid & msg_in.ready. Only beats advance state or counters; stalled valid is ignored.
//  - FSM states (wc_state_t): IDLE (between packets), IN_PKT.
//    IDLE: sop beat -> cntr=1; if eop, close the packet and stay in IDLE, else go to IN_PKT.
//          Beat without sop -> err[0] set, treated as sop (cntr=1), same transitions.
//    IN_PKT: beat without sop -> cntr+1; eop closes the packet -> IDLE.
//          sop beat -> err[1] set, previous packet dropped (no latch, no pkt_cnt), cntr=1, stay/close per eop.
//  - Close: last_len <= count incl. eop beat, last_len_vld=1 next cycle, pkt_cnt+1 (wraps).
//  - cntr/last_len registered: visible the cycle after the beat. cntr holds its value between packets.
//  - Width: SATURATE=1 holds cntr at 2**WORD_CNT_W-1; SATURATE=0 wraps to 0.
//  - too_long: beat making count > MAX_PKT_WORDS sets err[2] once per packet;
//    the packet still closes normally and is counted.
//  - clr_stats on the same cycle as a close or error: clear wins (pkt_cnt=0, err=0); last_len still updates.
//  - err_sticky bits are OR-set; multiple errors in one cycle all set.
// STRUCTURE
//  - aes_top_pack: typedef enum logic {WC_IDLE, WC_IN_PKT} wc_state_t;
//    localparams WC_ERR_NO_SOP=0, WC_ERR_NO_EOP=1, WC_ERR_TOO_LONG=2.
//  - Sub-module sat_counter #(W, SATURATE): load-1/increment/hold counter, instantiated for cntr.
//  - FSM, latch and pkt_cnt logic stay in this module.
// TESTING
//  - 4-beat packet (sop@1, eop@4), ready=1 -> cntr 1,2,3,4; last_len=4; last_len_vld 1 cycle; pkt_cnt=1.
//  - Same packet, ready toggled 0/1 each cycle -> identical counts; stalled cycles do not advance cntr.
//  - Single-beat sop&eop x3 -> last_len=1 each time; pkt_cnt=3; FSM never leaves IDLE.
//  - sop@1, beats 2-3, sop@4 ... eop@5 -> err[1]=1; last_len=2; pkt_cnt=1.
//  - WORD_CNT_W=3, SATURATE=1, 10-beat packet -> cntr sticks at 7; err[2] set; last_len=7.
//    With SATURATE=0 -> last_len=2.
//  - Reset asserted mid-packet, then clr_stats together with an eop beat -> all 0, then pkt_cnt=0, err=0.

Source files
------------

// File: rtl/aes_top_pack.sv
// Shared types and constants for the packet word counter.
package aes_top_pack;

    // Default width of the per-packet word counter and latched length.
    localparam int WORD_COUNTER_SIZE = 16;

    // Framing state: between packets, or inside an open packet.
    typedef enum logic {
        WC_IDLE   = 1'b0,
        WC_IN_PKT = 1'b1
    } wc_state_t;

    // Bit positions inside err_sticky.
    localparam int WC_ERR_NO_SOP   = 0;
    localparam int WC_ERR_NO_EOP   = 1;
    localparam int WC_ERR_TOO_LONG = 2;
    localparam int WC_ERR_W        = 3;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle with packet framing.
// Handshake: a beat transfers on a clock edge where valid and ready are both 1;
// the master holds valid/sop/eop/data stable until that happens, and ready may
// change freely.
interface avalon_st_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;

    modport master (output valid, output sop, output eop, output data, input ready);
    modport slave  (input valid, input sop, input eop, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Load-to-1 / increment / hold counter. At all-ones it either sticks
// (SATURATE=1) or wraps to zero (SATURATE=0). count_nxt exposes the value the
// register takes on the next edge so callers can latch it in the same cycle.
module sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] ALL_ONES = '1;

    // Next count: load wins over increment; the all-ones case picks stick or wrap.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = ONE;
        end else if (inc) begin
            if (count == ALL_ONES) begin
                count_nxt = SATURATE ? ALL_ONES : '0;
            end else begin
                count_nxt = count + ONE;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end
endmodule

// File: rtl/pkt_word_counter.sv
// In-line Avalon-ST packet monitor. The stream passes through untouched; only
// accepted beats move the framing FSM, the word counter, the length latch,
// the packet counter and the sticky error flags.
module pkt_word_counter
    import aes_top_pack::*;
#(
    parameter int WORD_CNT_W    = WORD_COUNTER_SIZE,
    parameter int PKT_CNT_W     = 32,
    parameter bit SATURATE      = 1'b1,
    parameter int MAX_PKT_WORDS = 2**WORD_CNT_W - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avalon_st_if.slave            msg_in,
    avalon_st_if.master           msg_out,
    input  logic                  clr_stats,
    output logic [WORD_CNT_W-1:0] cntr,
    output logic [WORD_CNT_W-1:0] last_len,
    output logic                  last_len_vld,
    output logic [PKT_CNT_W-1:0]  pkt_cnt,
    output logic [WC_ERR_W-1:0]   err_sticky
);
    localparam logic [WORD_CNT_W-1:0] MAX_W   = WORD_CNT_W'(MAX_PKT_WORDS);
    localparam logic [PKT_CNT_W-1:0]  PKT_ONE = PKT_CNT_W'(1);

    wc_state_t             state;
    wc_state_t             state_nxt;
    logic                  beat;
    logic                  cnt_load;
    logic                  cnt_inc;
    logic                  close_pkt;
    logic                  long_seen;
    logic [WC_ERR_W-1:0]   err_set;
    logic [WORD_CNT_W-1:0] cntr_nxt;

    // Pass-through is purely combinational so the monitor adds no latency.
    assign msg_out.valid = msg_in.valid;
    assign msg_out.sop   = msg_in.sop;
    assign msg_out.eop   = msg_in.eop;
    assign msg_out.data  = msg_in.data;
    assign msg_in.ready  = msg_out.ready;

    assign beat = msg_in.valid & msg_in.ready;

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: every beat opens or continues a packet, eop always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (beat) begin
            state_nxt = msg_in.eop ? WC_IDLE : WC_IN_PKT;
        end
    end

    // FSM outputs: counter control, packet close and framing errors for this beat.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        close_pkt = 1'b0;
        err_set   = '0;
        if (beat) begin
            close_pkt = msg_in.eop;
            case (state)
                WC_IDLE: begin
                    // A beat outside a packet is treated as its start either way.
                    cnt_load               = 1'b1;
                    err_set[WC_ERR_NO_SOP] = ~msg_in.sop;
                end
                WC_IN_PKT: begin
                    if (msg_in.sop) begin
                        // The open packet is abandoned; restart on this beat.
                        cnt_load               = 1'b1;
                        err_set[WC_ERR_NO_EOP] = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // The saturated/wrapped counter cannot show the overflow, so test before incrementing.
        err_set[WC_ERR_TOO_LONG] = cnt_inc & (cntr >= MAX_W) & ~long_seen;
    end

    sat_counter #(
        .W        (WORD_CNT_W),
        .SATURATE (SATURATE)
    ) u_word_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .count     (cntr),
        .count_nxt (cntr_nxt)
    );

    // Remembers that the current packet already raised too_long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_seen <= 1'b0;
        end else if (cnt_load) begin
            long_seen <= 1'b0;
        end else if (err_set[WC_ERR_TOO_LONG]) begin
            long_seen <= 1'b1;
        end
    end

    // Length latch with a one-cycle update strobe; not affected by clr_stats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_len     <= '0;
            last_len_vld <= 1'b0;
        end else begin
            last_len_vld <= close_pkt;
            if (close_pkt) begin
                last_len <= cntr_nxt;
            end
        end
    end

    // Packet counter and sticky errors; a clear in the same cycle overrides new events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt    <= '0;
            err_sticky <= '0;
        end else if (clr_stats) begin
            pkt_cnt    <= '0;
            err_sticky <= '0;
        end else begin
            if (close_pkt) begin
                pkt_cnt <= pkt_cnt + PKT_ONE;
            end
            err_sticky <= err_sticky | err_set;
        end
    end
endmodule
